hcsr04_emulator: RTL

HCSR04_EMULATOR -- requirements
Module: hcsr04_emulator

---
 rtl/hcsr04_pkg.sv | 26 ++
 rtl/hcsr04_emulator_sync_edge.sv | 41 ++++
 rtl/hcsr04_emulator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg
// Shared definitions for the HC-SR04 ultrasonic sensor emulator:
//   - state_t  : measurement FSM state encoding
//   - CM_US    : echo microseconds per centimetre of target distance
//   - MIN_CM / MAX_CM : in-range distance window
//   - TIMEOUT_US : no-object echo width used when HCSR04_EMU_TIMEOUT_EN is defined
//   - width_t  : 22-bit unsigned counter/width type
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam int CM_US      = 58;
  localparam int MIN_CM     = 2;
  localparam int MAX_CM     = 400;
  localparam int TIMEOUT_US = 38000;

  localparam int WIDTH_W = 22;
  typedef logic [WIDTH_W-1:0] width_t;

endpackage

// File: rtl/hcsr04_emulator_sync_edge.sv
// sync_edge
// Two-flop synchronizer for an asynchronous input pin followed by a
// rising/falling edge detector on the synchronized level.
// Ports:
//   clk  - block clock, rising edge active
//   rst  - asynchronous reset, active-low
//   din  - asynchronous input pin
//   sync - synchronized level (2 cycles after the pin)
//   rise - one-cycle pulse, first cycle sync is high
//   fall - one-cycle pulse, first cycle sync is low
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic din_p0;
  logic din_p1;
  logic din_p2;

  // Stage p0/p1: metastability filter; stage p2: previous level for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_p0 <= 1'b0;
      din_p1 <= 1'b0;
      din_p2 <= 1'b0;
    end else begin
      din_p0 <= din;
      din_p1 <= din_p0;
      din_p2 <= din_p1;
    end
  end

  assign sync = din_p1;
  assign rise = din_p1 & ~din_p2;
  assign fall = ~din_p1 & din_p2;

endmodule

// File: rtl/hcsr04_emulator.sv
// hcsr04_emulator
// Emulates the HC-SR04 ultrasonic ranging module seen from its trig/echo pins.
// A valid trigger (at least TRIG_MIN_US wide) starts a measurement: a fixed
// burst delay, then an echo pulse of distance*58 us, then a dead time.
// Parameters:
//   US_CYCLES   - clock cycles per microsecond
//   TRIG_MIN_US - minimum accepted trigger width (us)
//   BURST_US    - emulated ultrasonic burst time before echo rises (us)
//   HOLDOFF_US  - dead time after each measurement (us)
// Ports:
//   clk         - block clock, rising edge active
//   rst         - asynchronous reset, active-low
//   trig        - trigger pin, asynchronous to clk
//   distance_cm - emulated target distance in cm (sampled on burst entry)
//   echo        - echo pin, registered
//   busy        - high in every state except IDLE
//   trig_err    - one-cycle pulse when a trigger is rejected as too short
//   echo_done   - one-cycle pulse coincident with the echo falling edge
// Build option:
//   HCSR04_EMU_TIMEOUT_EN - out-of-range distances produce a 38 ms echo
//   instead of skipping the echo entirely.
module hcsr04_emulator
  import hcsr04_pkg::*;
#(
  parameter int US_CYCLES   = 40,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic       echo_done
);

  localparam width_t TRIG_MIN_CYC = width_t'(TRIG_MIN_US * US_CYCLES);
  localparam width_t BURST_CYC    = width_t'(BURST_US * US_CYCLES);
  localparam width_t HOLDOFF_CYC  = width_t'(HOLDOFF_US * US_CYCLES);

  // Width counter saturates so very long triggers cannot wrap below the minimum.
  function automatic width_t sat_inc(input width_t v, input width_t lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  // Echo length in cycles for a distance; zero means "no echo at all".
  function automatic width_t echo_cycles(input logic [8:0] cm);
    width_t w;
    if (cm >= 9'(MIN_CM) && cm <= 9'(MAX_CM)) begin
      w = width_t'(cm) * width_t'(CM_US * US_CYCLES);
    end else begin
`ifdef HCSR04_EMU_TIMEOUT_EN
      w = width_t'(TIMEOUT_US * US_CYCLES);
`else
      w = '0;
`endif
    end
    return w;
  endfunction

  logic   trig_s;
  logic   trig_rise;
  logic   trig_fall;

  state_t state;
  state_t state_next;
  width_t cnt;
  width_t cnt_next;
  width_t width_q;
  logic   load_width;
  logic   err_next;
  logic   done_next;

  sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (trig),
    .sync (trig_s),
    .rise (trig_rise),
    .fall (trig_fall)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_width = 1'b0;
    err_next   = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        // Only an edge starts a measurement; a level left high from an
        // earlier ignored trigger does not.
        if (trig_rise) begin
          state_next = TRIG_HI;
          cnt_next   = width_t'(1);
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          cnt_next = '0;
          if (cnt < TRIG_MIN_CYC) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            load_width = 1'b1;
            state_next = BURST;
          end
        end else if (trig_s) begin
          cnt_next = sat_inc(cnt, TRIG_MIN_CYC);
        end
      end
      BURST: begin
        if (cnt == BURST_CYC - 1'b1) begin
          cnt_next   = '0;
          // A zero width only arises for an out-of-range distance with the
          // timeout disabled: no echo pulse and no echo_done.
          state_next = (width_q != '0) ? ECHO : HOLDOFF;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ECHO: begin
        if (cnt == width_q - 1'b1) begin
          cnt_next   = '0;
          done_next  = 1'b1;
          state_next = HOLDOFF;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_CYC - 1'b1) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Control registers; echo is high exactly in the cycles the FSM sits in ECHO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      echo      <= 1'b0;
      trig_err  <= 1'b0;
      echo_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      echo      <= (state_next == ECHO);
      trig_err  <= err_next;
      echo_done <= done_next;
    end
  end

  // Distance-derived echo width, captured once on burst entry
  always_ff @(posedge clk) begin
    if (load_width) begin
      width_q <= echo_cycles(distance_cm);
    end
  end

  assign busy = (state != IDLE);

endmodule
